// File: rtl/oai_mult_seq.sv
// Bit-serial sequencer for the 12-column OAI multiplier array: streams one activation bit per cycle
// (LSB first), popcounts ~e and shift-accumulates a dot product. Optional early exit: OAI_SEQ_SKIP_ZERO_EN.
module oai_mult_seq #(
  parameter int LANES = 12,
  parameter int ACT_W = 8,
  parameter int ACC_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_w,
  input  logic [LANES*ACT_W-1:0]   in_x,
  input  logic [1:0]               in_op,
  output logic [LANES-1:0]         mult_a,
  output logic [LANES-1:0]         mult_b,
  output logic                     mult_c,
  output logic                     mult_d,
  input  logic [LANES-1:0]         mult_e,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sum,
  output logic                     busy
);

  localparam int POP_W = $clog2(LANES + 1);
  localparam int K_W   = (ACT_W > 1) ? $clog2(ACT_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // out_valid/out_sum stay stable until out_ready is seen; in_ready is high only in IDLE.
  state_t                   state_q;
  logic [K_W-1:0]           k_q;
  logic [ACC_W-1:0]         acc_q;
  logic [LANES*ACT_W-1:0]   x_q;
  logic [LANES-1:0]         mult_a_q, mult_b_q;
  logic                     mult_c_q, mult_d_q;
  logic                     in_ready_q, out_valid_q, busy_q;

  logic [K_W-1:0]           k_d;
  logic [ACC_W-1:0]         acc_d;
  logic [LANES-1:0]         inv_e;
  logic [POP_W-1:0]         pop;
  logic [LANES-1:0]         next_b, first_b;
  logic                     last;
  logic [ACT_W-1:0]         x_lane [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign x_lane[g] = x_q[g*ACT_W +: ACT_W];
  end

  assign inv_e = ~mult_e;
  assign k_d   = k_q + K_W'(1);

  always_comb begin
    pop     = '0;
    next_b  = '0;
    first_b = '0;
    for (int j = 0; j < LANES; j++) begin
      pop        = pop + POP_W'(inv_e[j]);
      next_b[j]  = x_lane[j][k_d];
      first_b[j] = in_x[j*ACT_W];
    end
    acc_d = acc_q + (ACC_W'(pop) << k_q);
    last  = (k_q == K_W'(ACT_W - 1));
`ifdef OAI_SEQ_SKIP_ZERO_EN
    // Ops with d=0 (00, 10) contribute nothing once every remaining activation bit is zero.
    begin
      logic hi_zero;
      hi_zero = 1'b1;
      for (int j = 0; j < LANES; j++) begin
        if (((x_lane[j] >> k_q) >> 1) != '0) hi_zero = 1'b0;
      end
      if (hi_zero && !mult_d_q) last = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      mult_c_q    <= 1'b1;
      mult_d_q    <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_q    <= S_RUN;
            k_q        <= '0;
            acc_q      <= '0;
            x_q        <= in_x;
            mult_a_q   <= in_w;
            mult_b_q   <= first_b;
            mult_c_q   <= in_op[1];
            mult_d_q   <= in_op[0];
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          if (last) begin
            // Park the array at e=0 while the result waits.
            state_q     <= S_DONE;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            mult_c_q    <= 1'b1;
            mult_d_q    <= 1'b1;
            out_valid_q <= 1'b1;
          end else begin
            k_q      <= k_d;
            mult_b_q <= next_b;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign busy      = busy_q;
  assign mult_a    = mult_a_q;
  assign mult_b    = mult_b_q;
  assign mult_c    = mult_c_q;
  assign mult_d    = mult_d_q;

endmodule

// File: tb/tb_oai_mult_seq.sv
// Self-checking bench for oai_mult_seq: directed test-plan steps plus random operations against
// an arithmetic reference model; latency expectations follow OAI_SEQ_SKIP_ZERO_EN when defined.
module tb_oai_mult_seq;

  localparam int LANES = 12;
  localparam int ACT_W = 8;
  localparam int ACC_W = 12;
  localparam int MAXV  = (1 << ACT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [LANES-1:0]       in_w = '0;
  logic [LANES*ACT_W-1:0] in_x = '0;
  logic [1:0]             in_op = '0;
  logic [LANES-1:0]       mult_a, mult_b, mult_e;
  logic                   mult_c, mult_d;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [ACC_W-1:0]       out_sum;
  logic                   busy;

  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0] exp_q[$];

  oai_mult_seq #(.LANES(LANES), .ACT_W(ACT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_w(in_w), .in_x(in_x), .in_op(in_op),
    .mult_a(mult_a), .mult_b(mult_b), .mult_c(mult_c), .mult_d(mult_d), .mult_e(mult_e),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
  );

  // Behavioural OAI array.
  assign mult_e = ~((mult_a | {LANES{mult_c}}) & (mult_b | {LANES{mult_d}}));

  // Clock / watchdog
  initial forever #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference model
  function automatic int model(input logic [LANES-1:0] w, input logic [LANES*ACT_W-1:0] x,
                               input logic [1:0] op);
    int s;
    s = 0;
    case (op)
      2'b00: for (int j = 0; j < LANES; j++) if (w[j]) s += int'(x[j*ACT_W +: ACT_W]);
      2'b01: s = $countones(w) * MAXV;
      2'b10: for (int j = 0; j < LANES; j++) s += int'(x[j*ACT_W +: ACT_W]);
      default: s = LANES * MAXV;
    endcase
    return s;
  endfunction

  function automatic int lat_of(input logic [LANES*ACT_W-1:0] x, input logic [1:0] op);
    int lat;
    logic [ACT_W-1:0] any_bits;
    lat = ACT_W + 1;
    any_bits = '0;
    for (int j = 0; j < LANES; j++) any_bits |= x[j*ACT_W +: ACT_W];
`ifdef OAI_SEQ_SKIP_ZERO_EN
    if (!op[0]) begin
      lat = 2;
      for (int b = 0; b < ACT_W; b++) if (any_bits[b]) lat = b + 2;
    end
`else
    if (any_bits === 'x && op === 'x) lat = 0;
`endif
    return lat;
  endfunction

  function automatic logic [LANES*ACT_W-1:0] fill(input logic [ACT_W-1:0] v);
    logic [LANES*ACT_W-1:0] x;
    for (int j = 0; j < LANES; j++) x[j*ACT_W +: ACT_W] = v;
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks: called #1 after a rising edge; return #1 after the accepting edge.
  task automatic send(input logic [LANES-1:0] w, input logic [LANES*ACT_W-1:0] x,
                      input logic [1:0] op);
    int n;
    in_w = w; in_x = x; in_op = op; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
    check("accept_wait", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(ACC_W'(model(w, x, op)));
    check("busy_after_accept", {30'b0, busy, in_ready}, 32'd2);
  endtask

  task automatic collect(input string tag, input int stall, input int lat_exp);
    int n;
    logic [ACC_W-1:0] held;
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
    check({tag, "_lat"}, n + 1, lat_exp);
    held = out_sum;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, {19'b0, out_valid, out_sum}, {19'b0, 1'b1, held});
    end
    check({tag, "_sum"}, out_sum, exp_q.pop_front());
    check({tag, "_park"}, {mult_a, mult_b, mult_c, mult_d}, {24'h0, 2'b11});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle"}, {29'b0, out_valid, in_ready, busy}, 32'd2);
  endtask

  task automatic do_op(input string tag, input logic [LANES-1:0] w,
                       input logic [LANES*ACT_W-1:0] x, input logic [1:0] op, input int stall);
    send(w, x, op);
    collect(tag, stall, lat_of(x, op));
  endtask

  // Directed steps followed by random operations
  initial begin
    logic [LANES*ACT_W-1:0] xr;
    logic [ACC_W-1:0] drop;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {29'b0, out_valid, in_ready, busy}, 32'd2);
    check("rst_sum", out_sum, 0);
    check("rst_mult", {mult_a, mult_b, mult_c, mult_d}, {24'h0, 2'b11});
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("and_fff_x3", 12'hFFF, fill(8'd3), 2'b00, 0);
    do_op("and_a5a_x255", 12'hA5A, fill(8'd255), 2'b00, 1);
    do_op("op01_a5a", 12'hA5A, fill(8'd255), 2'b01, 0);
    for (int j = 0; j < LANES; j++) xr[j*ACT_W +: ACT_W] = ACT_W'(j);
    do_op("op10_lane_j", 12'h000, xr, 2'b10, 0);
    do_op("op11_any", 12'h3C1, xr, 2'b11, 2);
    do_op("and_fff_x1", 12'hFFF, fill(8'd1), 2'b00, 0);
    do_op("and_fff_x0", 12'hFFF, fill(8'd0), 2'b00, 0);

    // Backpressure: a new request waits in DONE until the result handshake.
    send(12'hA5A, fill(8'd7), 2'b00);
    while (out_valid !== 1'b1 && checks < 100000) begin @(posedge clk); #1; end
    in_w = 12'hFFF; in_x = fill(8'd2); in_op = 2'b10; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {18'b0, out_valid, in_ready, out_sum}, {18'b0, 2'b10, 12'd42});
    end
    check("bp_sum", out_sum, exp_q.pop_front());
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", {29'b0, out_valid, in_ready, busy}, 32'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(ACC_W'(model(12'hFFF, fill(8'd2), 2'b10)));
    check("bp_next_accept", {31'b0, busy}, 32'd1);
    collect("bp_next", 0, lat_of(fill(8'd2), 2'b10));

    // Asynchronous reset in the middle of RUN (k=3).
    send(12'hFFF, fill(8'hF0), 2'b00);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_outputs", {29'b0, out_valid, in_ready, busy}, 32'd2);
    check("midrun_rst_sum", out_sum, 0);
    check("midrun_rst_mult", {mult_a, mult_b, mult_c, mult_d}, {24'h0, 2'b11});
    drop = exp_q.pop_back();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("after_rst_x1", 12'hFFF, fill(8'd1), 2'b00, 0);

    // Random operations.
    for (int t = 0; t < 16; t++) begin
      logic [LANES-1:0] wr;
      logic [1:0] opr;
      wr = LANES'($urandom);
      opr = 2'($urandom_range(0, 3));
      for (int j = 0; j < LANES; j++)
        xr[j*ACT_W +: ACT_W] = ACT_W'($urandom_range(0, MAXV) >> $urandom_range(0, ACT_W));
      do_op("rand", wr, xr, opr, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oai_mult_seq.md
Name: oai_mult_seq

Overview:
- Bit-serial sequencer for the 12-column OAI multiplier array (e = ~((a|c)&(b|d))) in the DCIM macro.
- Accepts one weight bitplane plus one multi-bit activation per lane and drives the multiplier one activation bit per cycle, LSB first.
- Reconstructs per-column products as ~e, popcounts them, and shift-accumulates into a single dot-product result.
- Sits between the macro input buffer and the output/readout logic; valid/ready handshakes on both sides.

Parameters:
- LANES, 12, multiplier column count (mult_a/b/e width).
- ACT_W, 8, activation bits per lane = serial cycles per operation.
- ACC_W, 12, result width; must be at least ACT_W + clog2(LANES+1).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  sequencer can accept a request
- in_w  in  LANES  weight bitplane, one bit per column
- in_x  in  LANES*ACT_W  activations; lane j = in_x[j*ACT_W +: ACT_W]
- in_op  in  2  {c,d} mode driven to the multiplier
- mult_a  out  LANES  multiplier a
- mult_b  out  LANES  multiplier b
- mult_c  out  1  multiplier c
- mult_d  out  1  multiplier d
- mult_e  in  LANES  multiplier e (combinational return)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  ACC_W  accumulated result
- busy  out  1  high in RUN or DONE

Behaviour:
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. When in_valid is high, latch in_w, in_x, in_op; clear acc and k; go to RUN.
  - RUN: cycle k (0..ACT_W-1).
    - mult_a = w_reg; mult_b[j] = x_reg lane j bit k; {mult_c, mult_d} = op_reg.
    - pop = popcount(~mult_e), sampled in the same cycle.
    - acc <= acc + (pop << k).
    - After k = ACT_W-1, go to DONE.
  - DONE: out_valid=1 and out_sum=acc, held stable until out_ready. On out_ready, go to IDLE.
- in_ready=0 outside IDLE. No overlap between operations; a request presented in DONE waits.
- Latency: request accepted at edge T; RUN occupies T+1..T+ACT_W; out_valid asserts from T+ACT_W+1.
  - Max throughput is one operation per ACT_W+2 cycles when out_ready is held high.
- Outside RUN: mult_a=0, mult_b=0, mult_c=1, mult_d=1, which parks the array at e=0.
- Result per op:
  - 00 (AND): sum over j of w_j*x_j.
  - 01: popcount(w) * (2^ACT_W-1).
  - 10: sum over j of x_j.
  - 11: LANES * (2^ACT_W-1).
- Arithmetic is unsigned. ACC_W is sized so no overflow is possible; no saturation logic.
- Reset (any state, including mid-RUN): state=IDLE, acc=0, k=0, latched regs=0, out_valid=0, out_sum=0, busy=0, in_ready=1 after release. Multiplier outputs take their parked values.
- in_valid while busy is ignored, with no side effects.

Optional Feature:
- Macro: OAI_SEQ_SKIP_ZERO_EN.
- Defined: in RUN, if ops 00/10 find all lane bits >= k+1 of x_reg zero after processing bit k, go to DONE immediately.
  - Latency = (index of highest set activation bit across lanes) + 2. All-zero x gives one RUN cycle.
  - Ops 01/11 always run ACT_W cycles.
- Undefined: always ACT_W RUN cycles; no extra logic.

Test Plan:
- w=FFF, all lanes x=3, op=00: out_sum=36. Without macro, out_valid exactly 9 cycles after accept.
- w=A5A, all lanes x=255, op=00: 1530. Same request with op=01 also gives 1530.
- Lane j x=j (j=0..11), w=000, op=10: 66. Op=11 with any operands: 3060.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. out_sum stays stable, in_ready=0, and a new in_valid is not accepted until after the out_ready handshake.
- Reset: drop rst_n at RUN k=3. All outputs return to reset values asynchronously; the next request (w=FFF, x=1, op=00) gives 12.
- With OAI_SEQ_SKIP_ZERO_EN: w=FFF, all lanes x=1, op=00 gives 12 with out_valid 2 cycles after accept. All lanes x=0 gives 0 after 2 cycles.
